// File: rtl/seqdet_prog.sv
// Programmable serial bit-pattern detector: runtime pattern/length/overlap,
// qualified serial input, registered one-cycle match pulse and saturating match counter.
module seqdet_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 16,
    parameter logic [MAX_LEN-1:0] DEF_PAT = 'h16,
    parameter int                 DEF_LEN = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               x_i,
    input  logic               x_vld_i,
    input  logic               cfg_ld_i,
    input  logic [MAX_LEN-1:0] cfg_pat_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_ovl_i,
    input  logic               clr_cnt_i,
    output logic               z_o,
    output logic [CNT_W-1:0]   match_cnt_o
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               match;
    logic               full;
    logic [MAX_LEN-1:0] hist_new;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   len_clamp;
    logic [CNT_W-1:0]   cnt_base;

    always_comb begin
        len_clamp = (cfg_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len_i;
        accept    = x_vld_i & ~cfg_ld_i;
        hist_new  = {hist_q[MAX_LEN-2:0], x_i};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        // fill+1 >= len means the window of the last len accepted bits is complete
        fill_inc = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        full     = (fill_inc >= {1'b0, len_q});
        match    = accept && (len_q != '0) && full && (((hist_new ^ pat_q) & mask) == '0);

        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = match;

        if (cfg_ld_i) begin
            pat_d  = cfg_pat_i;
            len_d  = len_clamp;
            ovl_d  = cfg_ovl_i;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_new;
            if (match && !ovl_q) begin
                fill_d = '0;
            end else begin
                fill_d = full ? len_q : fill_inc[LEN_W-1:0];
            end
        end

        // clear applies first so a simultaneous match leaves the count at one
        cnt_base = clr_cnt_i ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (match && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z_o         = z_q;
    assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seqdet_prog.sv
// Bench for seqdet_prog: directed steps plus random streams against a
// bit-list reference model; a second instance with a 2-bit counter shares the stimulus.
module tb_seqdet_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk;
  logic               rst_n;
  logic               x_i;
  logic               x_vld_i;
  logic               cfg_ld_i;
  logic [MAX_LEN-1:0] cfg_pat_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               cfg_ovl_i;
  logic               clr_cnt_i;
  logic               z_o;
  logic [15:0]        match_cnt_o;
  logic               z2_o;
  logic [1:0]         match_cnt2_o;

  int total;
  int bad;

  // reference model state
  int        m_len;
  logic [7:0] m_pat;
  logic      m_ovl;
  logic      bits_q[$];
  int        exp_cnt16;
  int        exp_cnt2;
  logic      exp_z;

  seqdet_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .x_vld_i(x_vld_i), .cfg_ld_i(cfg_ld_i),
    .cfg_pat_i(cfg_pat_i), .cfg_len_i(cfg_len_i), .cfg_ovl_i(cfg_ovl_i),
    .clr_cnt_i(clr_cnt_i), .z_o(z_o), .match_cnt_o(match_cnt_o)
  );

  seqdet_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .x_vld_i(x_vld_i), .cfg_ld_i(cfg_ld_i),
    .cfg_pat_i(cfg_pat_i), .cfg_len_i(cfg_len_i), .cfg_ovl_i(cfg_ovl_i),
    .clr_cnt_i(clr_cnt_i), .z_o(z2_o), .match_cnt_o(match_cnt2_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_len = 5;
    m_pat = 8'h16;
    m_ovl = 1'b1;
    bits_q.delete();
    exp_cnt16 = 0;
    exp_cnt2 = 0;
    exp_z = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    total++;
    assert (z_o === exp_z) else begin
      bad++;
      $error("FAIL %s z: got %0b want %0b", tag, z_o, exp_z);
    end
    total++;
    assert (z2_o === exp_z) else begin
      bad++;
      $error("FAIL %s z_c2: got %0b want %0b", tag, z2_o, exp_z);
    end
    total++;
    assert (match_cnt_o === 16'(exp_cnt16)) else begin
      bad++;
      $error("FAIL %s cnt16: got %0d want %0d", tag, match_cnt_o, exp_cnt16);
    end
    total++;
    assert (match_cnt2_o === 2'(exp_cnt2)) else begin
      bad++;
      $error("FAIL %s cnt2: got %0d want %0d", tag, match_cnt2_o, exp_cnt2);
    end
  endtask

  task automatic check_const(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // driver: one clock cycle of stimulus, model update, check just after the edge
  task automatic step(input logic x, input logic vld, input logic ld,
                      input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic clr, input string tag);
    logic hit;
    x_i = x; x_vld_i = vld; cfg_ld_i = ld;
    cfg_pat_i = pat; cfg_len_i = len; cfg_ovl_i = ovl; clr_cnt_i = clr;
    hit = 1'b0;
    if (ld) begin
      m_len = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
      m_pat = pat;
      m_ovl = ovl;
      bits_q.delete();
    end else if (vld) begin
      bits_q.push_back(x);
      if (bits_q.size() > MAX_LEN) void'(bits_q.pop_front());
      if (m_len > 0 && bits_q.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (bits_q[bits_q.size() - 1 - i] !== m_pat[i]) hit = 1'b0;
        if (hit && !m_ovl) bits_q.delete();
      end
    end
    if (clr) begin
      exp_cnt16 = 0;
      exp_cnt2 = 0;
    end
    if (hit) begin
      if (exp_cnt16 < 65535) exp_cnt16++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    exp_z = hit;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_bit(input logic x, input string tag);
    step(x, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input logic x, input string tag);
    step(x, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic x, input logic vld, input string tag);
    step(x, vld, 1'b1, pat, len, ovl, 1'b0, tag);
  endtask

  logic [7:0] stream8;
  logic [7:0] a5;
  int         cnt_snap;

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    x_i = 0; x_vld_i = 0; cfg_ld_i = 0; cfg_pat_i = '0; cfg_len_i = '0;
    cfg_ovl_i = 0; clr_cnt_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: default 10110 overlapping
    stream8 = 8'b10110110;
    for (int i = 7; i >= 0; i--) send_bit(stream8[i], "t1_bit");
    idle(1'b0, "t1_tail");
    check_const("t1_cnt", int'(match_cnt_o), 2);

    // 2: same stream, non-overlapping
    load(8'h16, 4'd5, 1'b0, 1'b0, 1'b0, "t2_load");
    for (int i = 7; i >= 0; i--) send_bit(stream8[i], "t2_bit");
    check_const("t2_cnt", int'(match_cnt_o), 3);

    // 3: default pattern with held-x gaps of three cycles
    load(8'h16, 4'd5, 1'b1, 1'b0, 1'b0, "t3_load");
    for (int i = 4; i >= 0; i--) begin
      send_bit(stream8[i + 3], "t3_bit");
      for (int g = 0; g < 3; g++) idle(stream8[i + 3], "t3_gap");
    end
    check_const("t3_cnt", int'(match_cnt_o), 4);

    // 4: reload mid-stream, load-cycle bit discarded, then 10100101
    send_bit(1'b1, "t4_pre"); send_bit(1'b0, "t4_pre"); send_bit(1'b1, "t4_pre");
    load(8'hA5, 4'd8, 1'b1, 1'b1, 1'b1, "t4_load");
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(a5[i], "t4_bit");
    check_const("t4_cnt", int'(match_cnt_o), 5);

    // length clamp and ignored upper pattern bits
    load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, "clamp_load");
    for (int i = 7; i >= 0; i--) send_bit(a5[i], "clamp_bit");
    load(8'hF6, 4'd5, 1'b1, 1'b0, 1'b0, "upper_load");
    for (int i = 7; i >= 0; i--) send_bit(stream8[i], "upper_bit");

    // 5: disabled detector
    load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, "t5_load");
    cnt_snap = int'(match_cnt_o);
    for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)), "t5_bit");
    check_const("t5_cnt", int'(match_cnt_o), cnt_snap);

    // 6: single-bit pattern, 2-bit counter saturation, clear with match
    load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, "t6_load");
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "t6_clr");
    for (int i = 0; i < 5; i++) send_bit(1'b1, "t6_one");
    check_const("t6_sat", int'(match_cnt2_o), 3);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "t6_clr_match");
    check_const("t6_clr16", int'(match_cnt_o), 1);
    check_const("t6_clr2", int'(match_cnt2_o), 1);

    // random configurations and streams
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        load(8'($urandom_range(0, 255)), 4'($urandom_range(0, 10)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), "rnd_load");
      else
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0,
             8'h00, 4'd0, 1'b0, ($urandom_range(0, 63) == 0), "rnd_bit");
    end

    // async reset mid-pattern, then restart from empty history
    load(8'h16, 4'd5, 1'b1, 1'b0, 1'b0, "rst_load");
    for (int i = 0; i < 5; i++) send_bit(1'b1, "rst_ones");
    send_bit(1'b1, "rst_pre"); send_bit(1'b0, "rst_pre"); send_bit(1'b1, "rst_pre");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_bit(1'b1, "post_rst"); send_bit(1'b0, "post_rst");
    for (int i = 4; i >= 0; i--) send_bit(stream8[i + 3], "post_rst_pat");
    check_const("post_rst_cnt", int'(match_cnt_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
